// File: rtl/mem_copy_engine.sv
// Byte copy engine: reads src range through the read port, writes it to dst through the write port.
// Optional MEMCPY_FILL_EN adds a fill mode that writes a constant byte without issuing reads.
module mem_copy_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  src_msb,
  input  logic [7:0]  src_lsb,
  input  logic [7:0]  dst_msb,
  input  logic [7:0]  dst_lsb,
  input  logic [15:0] len,
`ifdef MEMCPY_FILL_EN
  input  logic        fill,
  input  logic [7:0]  fill_val,
`endif
  output logic [7:0]  rd_msb_addr,
  output logic [7:0]  rd_lsb_addr,
  input  logic [7:0]  rd_val,
  output logic [7:0]  wr_msb_addr,
  output logic [7:0]  wr_lsb_addr,
  output logic [7:0]  wr_val,
  output logic        wr_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t      state, state_next;
  logic [15:0] rd_addr;
  logic [15:0] wr_addr;
  logic [15:0] remaining;
  logic        wr_en_q;
  logic        wr_en_next;
  logic        load;
  logic        rd_step;
  logic        fill_in;
  logic [7:0]  fill_val_in;
  logic        fill_q;
  logic [7:0]  fill_val_q;

`ifdef MEMCPY_FILL_EN
  assign fill_in     = fill;
  assign fill_val_in = fill_val;
`else
  assign fill_in     = 1'b0;
  assign fill_val_in = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    rd_step    = 1'b0;
    wr_en_next = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (len == 16'd0) begin
            state_next = FIN;
          end else begin
            state_next = RUN;
            // Fill writes start immediately; copy waits one cycle for read data.
            wr_en_next = fill_in;
          end
        end
      end
      RUN: begin
        if (remaining == 16'd1) state_next = fill_q ? FIN : DRAIN;
        if (fill_q) begin
          wr_en_next = (remaining != 16'd1);
        end else begin
          wr_en_next = 1'b1;
          rd_step    = (remaining != 16'd1);
        end
      end
      DRAIN:   state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr    <= 16'h0000;
      wr_addr    <= 16'h0000;
      remaining  <= 16'h0000;
      wr_en_q    <= 1'b0;
      count      <= 16'h0000;
      fill_q     <= 1'b0;
      fill_val_q <= 8'h00;
    end else begin
      wr_en_q <= wr_en_next;
      if (load) begin
        // In fill mode the read address is left untouched so the read port stays idle.
        if (!fill_in) rd_addr <= {src_msb, src_lsb};
        wr_addr    <= {dst_msb, dst_lsb};
        remaining  <= len;
        count      <= 16'h0000;
        fill_q     <= fill_in;
        fill_val_q <= fill_val_in;
      end else begin
        if (state == RUN) remaining <= remaining - 16'd1;
        if (rd_step)      rd_addr   <= rd_addr + 16'd1;
        if (wr_en_q) begin
          wr_addr <= wr_addr + 16'd1;
          count   <= count + 16'd1;
        end
      end
    end
  end

  // Masking with rst kills the in-flight write on the abort edge itself.
  assign wr_en       = wr_en_q & ~rst;
  assign wr_val      = wr_en ? (fill_q ? fill_val_q : rd_val) : 8'h00;
  assign rd_msb_addr = rd_addr[15:8];
  assign rd_lsb_addr = rd_addr[7:0];
  assign wr_msb_addr = wr_addr[15:8];
  assign wr_lsb_addr = wr_addr[7:0];
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == FIN);

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 64 KiB byte memory model (registered read).
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  src_msb, src_lsb, dst_msb, dst_lsb;
  logic [15:0] len;
`ifdef MEMCPY_FILL_EN
  logic        fill;
  logic [7:0]  fill_val;
`endif
  logic [7:0]  rd_msb_addr, rd_lsb_addr, rd_val;
  logic [7:0]  wr_msb_addr, wr_lsb_addr, wr_val;
  logic        wr_en, busy, done;
  logic [15:0] count;

  logic [7:0]  mem [0:65535];
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [7:0]  ld_dat;
  int          wr_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .src_msb(src_msb), .src_lsb(src_lsb), .dst_msb(dst_msb), .dst_lsb(dst_lsb),
    .len(len),
`ifdef MEMCPY_FILL_EN
    .fill(fill), .fill_val(fill_val),
`endif
    .rd_msb_addr(rd_msb_addr), .rd_lsb_addr(rd_lsb_addr), .rd_val(rd_val),
    .wr_msb_addr(wr_msb_addr), .wr_lsb_addr(wr_lsb_addr), .wr_val(wr_val),
    .wr_en(wr_en), .busy(busy), .done(done), .count(count)
  );

  always @(posedge clk) begin
    rd_val <= mem[{rd_msb_addr, rd_lsb_addr}];
    if (ld_en) mem[ld_addr] <= ld_dat;
    if (wr_en) begin
      mem[{wr_msb_addr, wr_lsb_addr}] <= wr_val;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke_mem(input logic [15:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_dat = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Starts a transfer and checks every cycle from 1 to one past done against the timing rules.
  task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                     input logic f, input logic [7:0] fv, input bit poke);
    logic [15:0] rd0, ea;
    int L, done_cyc, wlo, whi;
    rd0 = {rd_msb_addr, rd_lsb_addr};
    L = int'(l);
    done_cyc = (L == 0) ? 1 : (f ? L + 1 : L + 2);
    wlo = f ? 1 : 2;
    whi = f ? L : L + 1;
    {src_msb, src_lsb} = s; {dst_msb, dst_lsb} = d; len = l;
`ifdef MEMCPY_FILL_EN
    fill = f; fill_val = fv;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= done_cyc + 1; k++) begin
      check($sformatf("done c%0d", k), done, (k == done_cyc));
      if (k <= L) check($sformatf("busy c%0d", k), busy, 1);
      else if (k >= done_cyc) check($sformatf("busy c%0d", k), busy, 0);
      check($sformatf("wr_en c%0d", k), wr_en, (k >= wlo && k <= whi));
      if (k >= wlo && k <= whi) begin
        ea = d + 16'(k - wlo);
        check($sformatf("wr_addr c%0d", k), {wr_msb_addr, wr_lsb_addr}, ea);
        if (f) check($sformatf("wr_val c%0d", k), wr_val, fv);
        else   check($sformatf("wr_val c%0d", k), wr_val, mem[s + 16'(k - wlo)]);
      end
      if (f) check($sformatf("rd_hold c%0d", k), {rd_msb_addr, rd_lsb_addr}, rd0);
      else if (k <= L) check($sformatf("rd_addr c%0d", k), {rd_msb_addr, rd_lsb_addr}, s + 16'(k - 1));
      else if (L > 0) check($sformatf("rd_last c%0d", k), {rd_msb_addr, rd_lsb_addr}, s + 16'(L - 1));
      if (k == 1) check("count start", count, 0);
      if (k >= done_cyc) check($sformatf("count c%0d", k), count, l);
      if (poke) begin
        start = (k == 3);
        if (k == 3) begin
          {src_msb, src_lsb} = 16'h7000; {dst_msb, dst_lsb} = 16'h6000; len = 16'd2;
        end
      end
      if (k <= done_cyc) begin @(posedge clk); #1; end
    end
    start = 1'b0;
`ifdef MEMCPY_FILL_EN
    fill = 1'b0;
`endif
  endtask

  initial begin
    int wc0;
    rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
    {src_msb, src_lsb, dst_msb, dst_lsb} = '0; len = '0;
`ifdef MEMCPY_FILL_EN
    fill = 1'b0; fill_val = 8'h00;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst rd_addr", {rd_msb_addr, rd_lsb_addr}, 0);
    check("rst wr_addr", {wr_msb_addr, wr_lsb_addr}, 0);
    check("rst wr_val", wr_val, 0);
    check("rst wr_en", wr_en, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst count", count, 0);

    poke_mem(16'h1000, 8'h11); poke_mem(16'h1001, 8'h22);
    poke_mem(16'h1002, 8'h33); poke_mem(16'h1003, 8'h44);
    poke_mem(16'h10FE, 8'hA1); poke_mem(16'h10FF, 8'hB2);
    poke_mem(16'h1100, 8'hC3); poke_mem(16'h1101, 8'hD4);
    poke_mem(16'h3000, 8'h00); poke_mem(16'h3001, 8'h00);
    poke_mem(16'h4000, 8'h00); poke_mem(16'h6000, 8'h00);
    poke_mem(16'h0300, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic copy, then a second copy starting the cycle after FIN.
    run(16'h1000, 16'h2000, 16'd4, 1'b0, 8'h00, 1'b0);
    run(16'h1000, 16'h2100, 16'd4, 1'b0, 8'h00, 1'b0);
    check("basic 2000", mem[16'h2000], 8'h11);
    check("basic 2001", mem[16'h2001], 8'h22);
    check("basic 2002", mem[16'h2002], 8'h33);
    check("basic 2003", mem[16'h2003], 8'h44);
    check("b2b 2100", mem[16'h2100], 8'h11);
    check("b2b 2103", mem[16'h2103], 8'h44);

    run(16'h10FE, 16'hFFFE, 16'd4, 1'b0, 8'h00, 1'b0);
    check("wrap FFFE", mem[16'hFFFE], 8'hA1);
    check("wrap FFFF", mem[16'hFFFF], 8'hB2);
    check("wrap 0000", mem[16'h0000], 8'hC3);
    check("wrap 0001", mem[16'h0001], 8'hD4);

    wc0 = wr_cnt;
    run(16'h1000, 16'h4000, 16'd0, 1'b0, 8'h00, 1'b0);
    check("len0 writes", wr_cnt - wc0, 0);
    check("len0 mem", mem[16'h4000], 8'h00);

    run(16'h1000, 16'h5000, 16'd4, 1'b0, 8'h00, 1'b1);
    check("poke 5000", mem[16'h5000], 8'h11);
    check("poke 5003", mem[16'h5003], 8'h44);
    check("poke 6000", mem[16'h6000], 8'h00);
    check("poke idle", busy, 0);

`ifdef MEMCPY_FILL_EN
    run(16'h1234, 16'h0300, 16'd3, 1'b1, 8'hA5, 1'b0);
    check("fill 0300", mem[16'h0300], 8'hA5);
    check("fill 0301", mem[16'h0301], 8'hA5);
    check("fill 0302", mem[16'h0302], 8'hA5);
`endif

    // Abort a len=8 copy by asserting rst during cycle 3.
    wc0 = wr_cnt;
    {src_msb, src_lsb} = 16'h1000; {dst_msb, dst_lsb} = 16'h3000; len = 16'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort c2 wr_en", wr_en, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort wr_en", wr_en, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort count", count, 0);
    check("abort rd_addr", {rd_msb_addr, rd_lsb_addr}, 0);
    check("abort wr_addr", {wr_msb_addr, wr_lsb_addr}, 0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check($sformatf("post-abort done %0d", i), done, 0);
      check($sformatf("post-abort wr_en %0d", i), wr_en, 0);
    end
    check("abort writes", wr_cnt - wc0, 1);
    check("abort 3000", mem[16'h3000], 8'h11);
    check("abort 3001", mem[16'h3001], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
